// File: rtl/out_port_pkg_team1.sv
// Shared state encoding and frame-length helper for the OUT/FGO serial transmitter.
package out_port_pkg_team1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } txState_t;

   // Bit times in one frame: start + payload + optional parity + stop bits.
   function automatic int FRAME_BITS(input int dataBits, input int stopBits, input bit parityEn);
      return 1 + dataBits + (parityEn ? 1 : 0) + stopBits;
   endfunction

endpackage

// File: rtl/baud_tick_gen_team1.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick_gen_team1 #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic RST_N,
   input  logic restart_i,
   output logic tick_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == LAST);

   // Restart wins over counting so an accepted byte always starts a full bit time.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/out_port_tx_team1.sv
// OUT/FGO output device: serialises OUTR as an async frame on tx, LSB first.
// Define OUT_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after the data.
module out_port_tx_team1
   import out_port_pkg_team1::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 RST_N,
   input  logic                 CLR_GLOBAL,
   input  logic [DATA_BITS-1:0] OUTR_in,
   input  logic                 OUT_LD,
   output logic                 FGO,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 OVR
);

   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

   txState_t             state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IW-1:0]        bitIdx_q, bitIdx_d;
   logic                 fgo_q, fgo_d;
   logic                 ovr_q, ovr_d;
   logic                 busy_q, busy_d;
   logic                 tx_q, tx_d;
   logic                 accept;
   logic                 restart;
   logic                 tick;

`ifdef OUT_PARITY_EN
   logic parity_q, parity_d;
`else
   // PARITY_ODD has no effect when the parity bit is not built.
   if (PARITY_ODD != 0) begin : gParityOddIgnored
   end
`endif

   assign accept  = OUT_LD && fgo_q;
   assign restart = CLR_GLOBAL || accept || (state_q == IDLE);

   baud_tick_gen_team1 #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uBaud (
      .clk      (clk),
      .RST_N    (RST_N),
      .restart_i(restart),
      .tick_o   (tick)
   );

   // bitIdx counts bits already shifted out in DATA, and stop bits in STOP.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitIdx_d = bitIdx_q;
      fgo_d    = fgo_q;
      ovr_d    = ovr_q;
      busy_d   = busy_q;
      tx_d     = tx_q;
`ifdef OUT_PARITY_EN
      parity_d = parity_q;
`endif
      if (CLR_GLOBAL) begin
         state_d  = IDLE;
         shift_d  = '0;
         bitIdx_d = '0;
         fgo_d    = 1'b1;
         ovr_d    = 1'b0;
         busy_d   = 1'b0;
         tx_d     = 1'b1;
`ifdef OUT_PARITY_EN
         parity_d = 1'b0;
`endif
      end else begin
         if (OUT_LD && !fgo_q) begin
            ovr_d = 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d  = START;
                  shift_d  = OUTR_in;
                  bitIdx_d = '0;
                  fgo_d    = 1'b0;
                  busy_d   = 1'b1;
                  tx_d     = 1'b0;
`ifdef OUT_PARITY_EN
                  parity_d = (PARITY_ODD != 0) ? ~^OUTR_in : ^OUTR_in;
`endif
               end
            end
            START: begin
               if (tick) begin
                  state_d  = DATA;
                  tx_d     = shift_q[0];
                  shift_d  = shift_q >> 1;
                  bitIdx_d = '0;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bitIdx_q == LAST_DATA) begin
                     bitIdx_d = '0;
`ifdef OUT_PARITY_EN
                     state_d  = PARITY;
                     tx_d     = parity_q;
`else
                     state_d  = STOP;
                     tx_d     = 1'b1;
`endif
                  end else begin
                     tx_d     = shift_q[0];
                     shift_d  = shift_q >> 1;
                     bitIdx_d = bitIdx_q + IW'(1);
                  end
               end
            end
`ifdef OUT_PARITY_EN
            PARITY: begin
               if (tick) begin
                  state_d  = STOP;
                  tx_d     = 1'b1;
                  bitIdx_d = '0;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (bitIdx_q == LAST_STOP) begin
                     state_d  = IDLE;
                     fgo_d    = 1'b1;
                     busy_d   = 1'b0;
                     bitIdx_d = '0;
                  end else begin
                     bitIdx_d = bitIdx_q + IW'(1);
                  end
                  tx_d = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               fgo_d   = 1'b1;
               busy_d  = 1'b0;
               tx_d    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bitIdx_q <= '0;
         fgo_q    <= 1'b1;
         ovr_q    <= 1'b0;
         busy_q   <= 1'b0;
         tx_q     <= 1'b1;
`ifdef OUT_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitIdx_q <= bitIdx_d;
         fgo_q    <= fgo_d;
         ovr_q    <= ovr_d;
         busy_q   <= busy_d;
         tx_q     <= tx_d;
`ifdef OUT_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign FGO     = fgo_q;
   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign OVR     = ovr_q;

endmodule

// File: tb/tb_out_port_tx_team1.sv
// Directed bench for out_port_tx_team1 at CLKS_PER_BIT=4; parity frames checked when OUT_PARITY_EN is defined.
module tb_out_port_tx_team1;

   localparam int CPB = 4;
`ifdef OUT_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NBITS = 1 + 8 + PAR + 1;

   logic       clk;
   logic       RST_N;
   logic       CLR_GLOBAL;
   logic [7:0] OUTR_in;
   logic       OUT_LD;
   logic       FGO;
   logic       tx;
   logic       tx_busy;
   logic       OVR;

   int total;
   int bad;

   out_port_tx_team1 #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .STOP_BITS   (1),
      .PARITY_ODD  (0)
   ) dut (
      .clk       (clk),
      .RST_N     (RST_N),
      .CLR_GLOBAL(CLR_GLOBAL),
      .OUTR_in   (OUTR_in),
      .OUT_LD    (OUT_LD),
      .FGO       (FGO),
      .tx        (tx),
      .tx_busy   (tx_busy),
      .OVR       (OVR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle of stimulus, then inputs return to idle.
   task automatic applyStimulus(input logic ld, input logic [7:0] data, input logic clr);
      OUT_LD     = ld;
      OUTR_in    = data;
      CLR_GLOBAL = clr;
      step();
      OUT_LD     = 1'b0;
      CLR_GLOBAL = 1'b0;
   endtask

   function automatic logic expectedBit(input logic [7:0] data, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return data[idx-1];
      if (PAR == 1 && idx == 9) return ^data;
      return 1'b1;
   endfunction

   // Called one cycle after the accepting edge; optionally pulses OUT_LD=0x3C before edge injectAt+1.
   task automatic frameCheck(input logic [7:0] data, input int injectAt);
      for (int i = 0; i < NBITS * CPB; i++) begin
         checkOutput($sformatf("tx_%02h_c%0d", data, i), 32'(tx), 32'(expectedBit(data, i / CPB)));
         checkOutput($sformatf("fgo_%02h_c%0d", data, i), 32'(FGO), 32'd0);
         if (i == injectAt) begin
            OUT_LD  = 1'b1;
            OUTR_in = 8'h3C;
         end
         step();
         OUT_LD = 1'b0;
      end
      checkOutput($sformatf("fgoEnd_%02h", data), 32'(FGO), 32'd1);
      checkOutput($sformatf("busyEnd_%02h", data), 32'(tx_busy), 32'd0);
      checkOutput($sformatf("txEnd_%02h", data), 32'(tx), 32'd1);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      RST_N      = 1'b0;
      CLR_GLOBAL = 1'b0;
      OUT_LD     = 1'b0;
      OUTR_in    = 8'h00;
      step();
      step();
      checkOutput("rstFgo", 32'(FGO), 32'd1);
      checkOutput("rstTx", 32'(tx), 32'd1);
      checkOutput("rstBusy", 32'(tx_busy), 32'd0);
      checkOutput("rstOvr", 32'(OVR), 32'd0);
      RST_N = 1'b1;
      step();

      $display("[TB] basic frame 0xA5");
      applyStimulus(1'b1, 8'hA5, 1'b0);
      checkOutput("busyA5", 32'(tx_busy), 32'd1);
      frameCheck(8'hA5, -1);
      checkOutput("ovrA5", 32'(OVR), 32'd0);
      step();

      $display("[TB] overrun mid-frame");
      applyStimulus(1'b1, 8'h11, 1'b0);
      frameCheck(8'h11, 10);
      checkOutput("ovrSticky", 32'(OVR), 32'd1);
      step();
      checkOutput("ovrStill", 32'(OVR), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("clrOvr", 32'(OVR), 32'd0);
      checkOutput("clrFgo", 32'(FGO), 32'd1);

      $display("[TB] reset during frame");
      applyStimulus(1'b1, 8'h81, 1'b0);
      for (int i = 0; i < 13; i++) step();
      checkOutput("preRstFgo", 32'(FGO), 32'd0);
      RST_N = 1'b0;
      #1;
      checkOutput("abortTx", 32'(tx), 32'd1);
      checkOutput("abortFgo", 32'(FGO), 32'd1);
      checkOutput("abortBusy", 32'(tx_busy), 32'd0);
      step();
      RST_N = 1'b1;
      step();
      applyStimulus(1'b1, 8'h81, 1'b0);
      frameCheck(8'h81, -1);

      $display("[TB] back-to-back");
      step();
      applyStimulus(1'b1, 8'h5A, 1'b0);
      frameCheck(8'h5A, NBITS * CPB - 1);
      checkOutput("b2bOvr", 32'(OVR), 32'd1);
      applyStimulus(1'b1, 8'hC3, 1'b0);
      checkOutput("b2bTx", 32'(tx), 32'd0);
      frameCheck(8'hC3, -1);
      applyStimulus(1'b0, 8'h00, 1'b1);

`ifdef OUT_PARITY_EN
      $display("[TB] parity frame 0x07");
      applyStimulus(1'b1, 8'h07, 1'b0);
      checkOutput("parBit", 32'(expectedBit(8'h07, 9)), 32'd1);
      frameCheck(8'h07, -1);
`endif

      $display("[TB] clear wins over load");
      applyStimulus(1'b1, 8'h55, 1'b1);
      checkOutput("clrLdTx", 32'(tx), 32'd1);
      checkOutput("clrLdFgo", 32'(FGO), 32'd1);
      checkOutput("clrLdBusy", 32'(tx_busy), 32'd0);
      checkOutput("clrLdOvr", 32'(OVR), 32'd0);
      step();
      step();
      checkOutput("clrLdTx2", 32'(tx), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
